// File: rtl/ysyx_22050612_lsu_pkg.sv
// rtl/ysyx_22050612_lsu_pkg.sv - LSU state and access-size encodings
package ysyx_22050612_lsu_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE  = 2'd0;
  localparam lsu_state_t ST_MREQ  = 2'd1;
  localparam lsu_state_t ST_MWAIT = 2'd2;
  localparam lsu_state_t ST_RESP  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/ysyx_22050612_LsuAlign.sv
// rtl/ysyx_22050612_LsuAlign.sv - byte-lane shift, write mask and load extension
module ysyx_22050612_LsuAlign
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [1:0]                size_i,
  input  logic                      uns_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           rdata_i,
  output logic [XLEN/8-1:0]         wmask_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           load_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(XLEN);

  logic [OFFW+2:0]  shamt;
  logic [NB-1:0]    base;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  keep;
  logic [IW-1:0]    msb;
  logic             sign;

  assign shamt   = {off_i, 3'b000};
  assign wmask_o = base << off_i;
  assign wdata_o = wdata_i << shamt;
  assign shifted = rdata_i >> shamt;

  always_comb begin
    base = NB'(8'hFF);
    keep = '1;
    msb  = IW'(XLEN - 1);
    case (size_i)
      SZ_B: begin base = NB'(1);  keep = XLEN'(8'hFF);         msb = IW'(7);  end
      SZ_H: begin base = NB'(3);  keep = XLEN'(16'hFFFF);      msb = IW'(15); end
      SZ_W: begin base = NB'(15); keep = XLEN'(32'hFFFF_FFFF); msb = IW'(31); end
      default: ;
    endcase
  end

  // Double-word keeps every bit, so the unsigned flag has no effect there.
  assign sign   = ~uns_i & shifted[msb];
  assign load_o = (shifted & keep) | ({XLEN{sign}} & ~keep);

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// rtl/ysyx_22050612_lsu.sv - multi-cycle load/store unit with handshaked memory port
module ysyx_22050612_lsu
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_gpr_wen,
  output logic              resp_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            wen_q, wen_d;
  logic            err_q, err_d;
  logic [4:0]      rd_q, rd_d;

  logic            misaligned;
  logic            illegal;
  logic [NB-1:0]   lane_wmask;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;
  logic            in_mreq;
  logic            in_resp;
  logic            is_store_req;
  logic            load_ok;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign illegal = (req_size == SZ_D) && (XLEN == 32);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wen_d   = wen_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wen_d   = req_wen;
          rd_d    = req_rd;
          err_d   = misaligned | illegal;
          state_d = (misaligned | illegal) ? ST_RESP : ST_MREQ;
        end
      end
      ST_MREQ: begin
        if (mem_req_ready) state_d = ST_MWAIT;
      end
      ST_MWAIT: begin
        // Stores wait here too, so the ack is consumed before writeback.
        if (mem_resp_valid) begin
          if (!wen_q) rdata_d = mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  ysyx_22050612_LsuAlign #(.XLEN(XLEN)) u_align (
    .off_i   (addr_q[OFFW-1:0]),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .rdata_i (rdata_q),
    .wmask_o (lane_wmask),
    .wdata_o (lane_wdata),
    .load_o  (load_data)
  );

  assign in_mreq      = (state_q == ST_MREQ);
  assign in_resp      = (state_q == ST_RESP);
  assign is_store_req = in_mreq & wen_q;
  assign load_ok      = in_resp & ~wen_q & ~err_q;

  // Outputs are forced to zero outside their owning state.
  assign req_ready     = (state_q == ST_IDLE);
  assign mem_req_valid = in_mreq;
  assign mem_addr      = in_mreq ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_wen       = is_store_req;
  assign mem_wdata     = is_store_req ? lane_wdata : '0;
  assign mem_wmask     = is_store_req ? lane_wmask : '0;
  assign resp_valid    = in_resp;
  assign resp_err      = in_resp & err_q;
  assign resp_rd       = in_resp ? rd_q : 5'd0;
  assign resp_data     = load_ok ? load_data : '0;
  assign resp_gpr_wen  = load_ok & (rd_q != 5'd0);

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// tb/tb_ysyx_22050612_lsu.sv - directed table-driven bench for the LSU
module tb_ysyx_22050612_lsu;
  import ysyx_22050612_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        resp_valid, resp_ready, resp_gpr_wen, resp_err;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;

  logic        req_valid32, req_ready32, mem_req_valid32, mem_wen32;
  logic [31:0] mem_addr32, mem_wdata32, resp_data32;
  logic [3:0]  mem_wmask32;
  logic        resp_valid32, resp_gpr_wen32, resp_err32;
  logic [4:0]  resp_rd32;

  ysyx_22050612_lsu #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_gpr_wen(resp_gpr_wen), .resp_err(resp_err)
  );

  ysyx_22050612_lsu #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_wen(1'b0),
    .req_size(SZ_D), .req_unsigned(1'b0), .req_addr(32'h0000_0010),
    .req_wdata(32'h0), .req_rd(5'd3),
    .mem_req_valid(mem_req_valid32), .mem_req_ready(1'b1),
    .mem_addr(mem_addr32), .mem_wen(mem_wen32), .mem_wdata(mem_wdata32),
    .mem_wmask(mem_wmask32), .mem_resp_valid(1'b1), .mem_rdata(32'hFFFF_FFFF),
    .resp_valid(resp_valid32), .resp_ready(1'b1), .resp_data(resp_data32),
    .resp_rd(resp_rd32), .resp_gpr_wen(resp_gpr_wen32), .resp_err(resp_err32)
  );

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] m_addr;
    logic [7:0]  m_mask;
    logic [63:0] m_wdata;
    logic [63:0] r_data;
    logic        gpr;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  int n_tests = 0;
  int n_fail  = 0;
  int hs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = v.wen; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = v.rdata; resp_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d req_ready_idle", i), 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (v.err) begin
      check($sformatf("v%0d err_mem_req_valid", i), 64'(mem_req_valid), 64'd0);
    end else begin
      check($sformatf("v%0d mem_req_valid", i), 64'(mem_req_valid), 64'd1);
      check($sformatf("v%0d mem_addr", i), mem_addr, v.m_addr);
      check($sformatf("v%0d mem_wmask", i), 64'(mem_wmask), 64'(v.m_mask));
      check($sformatf("v%0d mem_wdata", i), mem_wdata, v.m_wdata);
      check($sformatf("v%0d mem_wen", i), 64'(mem_wen), 64'(v.wen));
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d mwait_resp_valid", i), 64'(resp_valid), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    check($sformatf("v%0d resp_valid", i), 64'(resp_valid), 64'd1);
    check($sformatf("v%0d resp_err", i), 64'(resp_err), 64'(v.err));
    check($sformatf("v%0d resp_data", i), resp_data, v.r_data);
    check($sformatf("v%0d resp_gpr_wen", i), 64'(resp_gpr_wen), 64'(v.gpr));
    check($sformatf("v%0d resp_rd", i), 64'(resp_rd), 64'(v.rd));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    //           wen   size  uns   addr                   wdata                  rd     rdata                   err   m_addr          m_mask  m_wdata                r_data                 gpr
    vecs[0]  = '{1'b0, SZ_W, 1'b0, 64'h8000_0004,         64'h0,                 5'd5,  64'h8000_0000_1234_5678, 1'b0, 64'h8000_0000, 8'h00, 64'h0,                 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[1]  = '{1'b0, SZ_B, 1'b1, 64'h8000_0003,         64'h0,                 5'd1,  64'h0000_0000_F100_0000, 1'b0, 64'h8000_0000, 8'h00, 64'h0,                 64'h0000_0000_0000_00F1, 1'b1};
    vecs[2]  = '{1'b1, SZ_H, 1'b0, 64'h8000_0006,         64'hABCD,              5'd7,  64'h0,                   1'b0, 64'h8000_0000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0,                 1'b0};
    vecs[3]  = '{1'b0, SZ_W, 1'b0, 64'h8000_0002,         64'h0,                 5'd4,  64'h0,                   1'b1, 64'h0,         8'h00, 64'h0,                 64'h0,                 1'b0};
    vecs[4]  = '{1'b0, SZ_B, 1'b0, 64'h8000_0001,         64'h0,                 5'd9,  64'h0000_0000_0000_8000, 1'b0, 64'h8000_0000, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
    vecs[5]  = '{1'b0, SZ_H, 1'b0, 64'h8000_000A,         64'h0,                 5'd10, 64'h0000_0000_9876_0000, 1'b0, 64'h8000_0008, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_9876, 1'b1};
    vecs[6]  = '{1'b0, SZ_H, 1'b1, 64'h8000_000E,         64'h0,                 5'd0,  64'hBEEF_0000_0000_0000, 1'b0, 64'h8000_0008, 8'h00, 64'h0,                 64'h0000_0000_0000_BEEF, 1'b0};
    vecs[7]  = '{1'b0, SZ_D, 1'b1, 64'h8000_0008,         64'h0,                 5'd31, 64'h8123_4567_89AB_CDEF, 1'b0, 64'h8000_0008, 8'h00, 64'h0,                 64'h8123_4567_89AB_CDEF, 1'b1};
    vecs[8]  = '{1'b1, SZ_D, 1'b0, 64'h8000_0010,         64'h1122_3344_5566_7788, 5'd2, 64'h0,                 1'b0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'h0,                 1'b0};
    vecs[9]  = '{1'b1, SZ_B, 1'b0, 64'h8000_0005,         64'h5A,                5'd3,  64'h0,                   1'b0, 64'h8000_0000, 8'h20, 64'h0000_5A00_0000_0000, 64'h0,                 1'b0};
    vecs[10] = '{1'b1, SZ_W, 1'b0, 64'h8000_000C,         64'hDEAD_BEEF,         5'd6,  64'h0,                   1'b0, 64'h8000_0008, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0,                 1'b0};
    vecs[11] = '{1'b0, SZ_D, 1'b0, 64'h8000_0004,         64'h0,                 5'd8,  64'h0,                   1'b1, 64'h0,         8'h00, 64'h0,                 64'h0,                 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = SZ_B; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = '0; resp_ready = 1'b0; req_valid32 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst mem_addr", mem_addr, 64'd0);
    check("rst resp_data", resp_data, 64'd0);
    check("rst resp_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // XLEN=32 rejects a double-word access without touching the bus.
    @(posedge clk); #1;
    req_valid32 = 1'b1;
    @(posedge clk); #1;
    req_valid32 = 1'b0;
    @(negedge clk);
    check("x32 resp_valid", 64'(resp_valid32), 64'd1);
    check("x32 resp_err", 64'(resp_err32), 64'd1);
    check("x32 mem_req_valid", 64'(mem_req_valid32), 64'd0);

    // Backpressure on both sides with a single store.
    hs = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 64'h8000_0008; req_wdata = 64'h1234_5678; req_rd = 5'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d mem_req_valid", c), 64'(mem_req_valid), 64'd1);
      check($sformatf("bp%0d mem_addr", c), mem_addr, 64'h8000_0008);
      check($sformatf("bp%0d mem_wmask", c), 64'(mem_wmask), 64'h0F);
      check($sformatf("bp%0d mem_wdata", c), mem_wdata, 64'h1234_5678);
      check($sformatf("bp%0d req_ready", c), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("bp mwait mem_req_valid", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bpr%0d resp_valid", c), 64'(resp_valid), 64'd1);
      check($sformatf("bpr%0d resp_err", c), 64'(resp_err), 64'd0);
      check($sformatf("bpr%0d req_ready", c), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) hs++;
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    check("bp handshakes", 64'(hs), 64'd1);
    @(negedge clk);
    check("bp back to idle", 64'(req_ready), 64'd1);

    // Reset while waiting for read data, then a late response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_size = SZ_W; req_addr = 64'h8000_0004; req_rd = 5'd5;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("rstmid req_ready before", 64'(req_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid req_ready", 64'(req_ready), 64'd1);
    check("rstmid mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rstmid resp_valid", 64'(resp_valid), 64'd0);
    check("rstmid resp_data", resp_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("late%0d resp_valid", c), 64'(resp_valid), 64'd0);
      check($sformatf("late%0d req_ready", c), 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    run_vec(100, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
